// File: rtl/vram_arbiter.sv
// Two-port VRAM arbiter: video fetch (A), CPU (B) and refresh share one memory controller.
// One command is in flight at a time; refresh credits accumulate and preempt when urgent.
module vram_arbiter #(
  parameter int REFRESH_PERIOD = 405,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        a_req,
  input  logic [21:0] a_addr,
  output logic        a_ack,
  output logic [15:0] a_rdata,
  output logic        a_rvalid,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [21:0] b_addr,
  input  logic [15:0] b_wdata,
  input  logic [1:0]  b_wdm,
  output logic        b_ack,
  output logic [15:0] b_rdata,
  output logic        b_rvalid,
  output logic        mc_read,
  output logic        mc_write,
  output logic        mc_refresh,
  output logic [21:0] mc_addr,
  output logic [15:0] mc_din,
  output logic [1:0]  mc_wdm,
  input  logic [15:0] mc_dout,
  input  logic        mc_busy,
  input  logic        mc_enabled,
  output logic        err
);
  localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE} state_t;
  typedef enum logic [1:0] {G_NONE, G_A, G_B, G_REF} gnt_t;

  state_t          state, state_nx;
  gnt_t            gnt;
  logic            timeout;
  logic [2:0]      wcnt;
  logic [RW-1:0]   ref_cnt;
  logic            ref_wrap;
  logic [2:0]      pending;
  logic [SW-1:0]   a_cnt;
  logic            cur_rd, cur_a;
  logic            rd_pend, rd_a;
  logic [15:0]     rd_buf;
  logic            b_rd;

  assign ref_wrap = mc_enabled && (ref_cnt == RW'(REFRESH_PERIOD - 1));
  assign b_rd     = !b_we;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else         state <= state_nx;

  always_comb begin
    state_nx = state;
    gnt      = G_NONE;
    timeout  = 1'b0;
    case (state)
      IDLE: begin
        if (!mc_busy && mc_enabled) begin
          if (pending >= 3'd4)                           gnt = G_REF;
          else if (b_req && a_cnt >= SW'(STARVE_LIMIT))  gnt = G_B;
          else if (a_req)                                gnt = G_A;
          else if (pending != 3'd0)                      gnt = G_REF;
          else if (b_req)                                gnt = G_B;
        end
        if (gnt != G_NONE) state_nx = ISSUE;
      end
      ISSUE: state_nx = WAIT_ACCEPT;
      WAIT_ACCEPT: begin
        if (mc_busy) state_nx = WAIT_DONE;
        else if (wcnt == 3'd7) begin
          state_nx = IDLE;
          timeout  = 1'b1;
        end
      end
      WAIT_DONE: if (!mc_busy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes and acks are only ever set from an IDLE grant, so they last exactly the ISSUE cycle.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      mc_read <= 1'b0; mc_write <= 1'b0; mc_refresh <= 1'b0;
      mc_addr <= '0;   mc_din <= '0;     mc_wdm <= '0;
      a_ack <= 1'b0;   b_ack <= 1'b0;
      cur_rd <= 1'b0;  cur_a <= 1'b0;
    end else begin
      mc_read    <= (gnt == G_A) || (gnt == G_B && b_rd);
      mc_write   <= (gnt == G_B) && b_we;
      mc_refresh <= (gnt == G_REF);
      a_ack      <= (gnt == G_A);
      b_ack      <= (gnt == G_B);
      if (gnt != G_NONE) begin
        mc_addr <= (gnt == G_A) ? a_addr : (gnt == G_B) ? b_addr : '0;
        mc_din  <= (gnt == G_B && b_we) ? b_wdata : '0;
        mc_wdm  <= (gnt == G_B && b_we) ? b_wdm : 2'b11;
        cur_rd  <= (gnt == G_A) || (gnt == G_B && b_rd);
        cur_a   <= (gnt == G_A);
      end
    end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wcnt <= '0; err <= 1'b0;
    end else begin
      wcnt <= (state == WAIT_ACCEPT) ? wcnt + 3'd1 : 3'd0;
      if (timeout) err <= 1'b1;
    end

  // Read data is captured on busy release and presented with rvalid one cycle later.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rd_pend <= 1'b0; rd_a <= 1'b0; rd_buf <= '0;
      a_rvalid <= 1'b0; b_rvalid <= 1'b0;
      a_rdata <= '0;    b_rdata <= '0;
    end else begin
      rd_pend <= (state == WAIT_DONE) && !mc_busy && cur_rd;
      if (state == WAIT_DONE && !mc_busy) begin
        rd_buf <= mc_dout;
        rd_a   <= cur_a;
      end
      a_rvalid <= rd_pend && rd_a;
      b_rvalid <= rd_pend && !rd_a;
      if (rd_pend && rd_a)  a_rdata <= rd_buf;
      if (rd_pend && !rd_a) b_rdata <= rd_buf;
    end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      ref_cnt <= '0; pending <= '0; a_cnt <= '0;
    end else begin
      if (!mc_enabled || ref_wrap) ref_cnt <= '0;
      else                         ref_cnt <= ref_cnt + 1'b1;
      if (!mc_enabled) pending <= '0;
      else if (ref_wrap && gnt != G_REF && pending != 3'd7) pending <= pending + 3'd1;
      else if (!ref_wrap && gnt == G_REF)                   pending <= pending - 3'd1;
      if (gnt == G_B || !b_req)                         a_cnt <= '0;
      else if (gnt == G_A && a_cnt < SW'(STARVE_LIMIT)) a_cnt <= a_cnt + 1'b1;
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a small busy-counting memory controller model.
module tb_vram_arbiter;
  localparam int RP = 64;

  logic        clk = 1'b0, resetn;
  logic        a_req, b_req, b_we;
  logic [21:0] a_addr, b_addr;
  logic [15:0] b_wdata;
  logic [1:0]  b_wdm;
  logic        a_ack, a_rvalid, b_ack, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic        mc_read, mc_write, mc_refresh;
  logic [21:0] mc_addr;
  logic [15:0] mc_din, mc_dout;
  logic [1:0]  mc_wdm;
  logic        mc_busy, mc_enabled, err;

  vram_arbiter #(.REFRESH_PERIOD(RP), .STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_wdm(b_wdm),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .mc_read(mc_read), .mc_write(mc_write), .mc_refresh(mc_refresh),
    .mc_addr(mc_addr), .mc_din(mc_din), .mc_wdm(mc_wdm),
    .mc_dout(mc_dout), .mc_busy(mc_busy), .mc_enabled(mc_enabled), .err(err)
  );

  always #5 clk = ~clk;

  // Controller model: busy for busy_len cycles after each command strobe.
  int          busy_cnt = 0;
  int          busy_len = 4;
  bit          no_resp = 1'b0, hold_busy = 1'b0;
  logic [15:0] model_dout = 16'h0;
  always @(posedge clk)
    if ((mc_read || mc_write || mc_refresh) && !no_resp) busy_cnt <= busy_len;
    else if (busy_cnt > 0)                               busy_cnt <= busy_cnt - 1;
  assign mc_busy = hold_busy || (busy_cnt > 0);
  assign mc_dout = model_dout;

  // Monitor
  int          cyc = 0;
  bit          clr = 1'b0;
  int          a_ack_n, b_ack_n, rd_n, wr_n, ref_n, a_rv_n, b_rv_n, rd_cyc, rv_cyc;
  logic [21:0] last_addr;
  logic [15:0] last_din;
  logic [1:0]  last_wdm;
  byte         log_q[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (clr) begin
      a_ack_n <= 0; b_ack_n <= 0; rd_n <= 0; wr_n <= 0; ref_n <= 0;
      a_rv_n <= 0; b_rv_n <= 0; rd_cyc <= 0; rv_cyc <= 0;
      last_addr <= '0; last_din <= '0; last_wdm <= '0;
      log_q.delete();
    end else begin
      if (a_ack) begin a_ack_n <= a_ack_n + 1; log_q.push_back("A"); end
      if (b_ack) begin b_ack_n <= b_ack_n + 1; log_q.push_back("B"); end
      if (mc_refresh) begin ref_n <= ref_n + 1; log_q.push_back("R"); end
      if (mc_read) begin rd_n <= rd_n + 1; rd_cyc <= cyc; end
      if (mc_write) wr_n <= wr_n + 1;
      if (a_rvalid) begin a_rv_n <= a_rv_n + 1; rv_cyc <= cyc; end
      if (b_rvalid) b_rv_n <= b_rv_n + 1;
      if (mc_read || mc_write || mc_refresh) begin
        last_addr <= mc_addr; last_din <= mc_din; last_wdm <= mc_wdm;
      end
    end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    resetn = 1'b0; a_req = 0; b_req = 0; b_we = 0;
    a_addr = '0; b_addr = '0; b_wdata = '0; b_wdm = '0;
    no_resp = 0; hold_busy = 0; clr = 1;
    tick(2);
    clr = 0; resetn = 1'b1; mc_enabled = 1'b1;
  endtask

  task automatic wait_ack(input bit port_b, input string tag);
    int n = 0;
    while (!(port_b ? b_ack : a_ack) && n < 100) begin tick(1); n++; end
    chk(tag, port_b ? b_ack : a_ack, 1'b1);
  endtask

  function automatic logic [95:0] log_str(input int n);
    logic [95:0] s = '0;
    for (int i = 0; i < n && i < log_q.size(); i++) s = {s[87:0], log_q[i]};
    return s;
  endfunction

  initial begin
    resetn = 1'b0; mc_enabled = 1'b0; a_req = 0; b_req = 0; b_we = 0;
    a_addr = '0; b_addr = '0; b_wdata = '0; b_wdm = '0;
    #12;
    chk("rst_strobes", {mc_read, mc_write, mc_refresh, a_ack, b_ack, a_rvalid, b_rvalid, err}, 8'h00);
    chk("rst_rdata", {a_rdata, b_rdata}, 32'h0);

    // Single A read, 4 busy cycles
    do_reset();
    busy_len = 4; model_dout = 16'hBEEF;
    a_addr = 22'h000100; a_req = 1;
    wait_ack(0, "rd_ack");
    a_req = 0;
    tick(20);
    chk("rd_ack_cnt", a_ack_n, 1);
    chk("rd_strobe_cnt", rd_n, 1);
    chk("rd_rvalid_cnt", a_rv_n, 1);
    chk("rd_rdata", a_rdata, 16'hBEEF);
    chk("rd_latency", rv_cyc - rd_cyc, 7);
    chk("rd_addr", last_addr, 22'h000100);
    chk("rd_wdm", last_wdm, 2'b11);

    // Both ports continuously requesting
    do_reset();
    busy_len = 2; model_dout = 16'h1111;
    a_req = 1; b_req = 1;
    begin
      int n = 0;
      while (log_q.size() < 10 && n < 300) begin tick(1); n++; end
    end
    chk("starve_order", log_str(10), "AAAABAAAAB");
    chk("starve_backs", b_ack_n, 2);
    a_req = 0; b_req = 0;
    tick(10);

    // Refresh credits accumulate under a long busy; saturate at 7
    do_reset();
    busy_len = 2; hold_busy = 1; a_req = 1;
    tick(8 * RP + 5);
    hold_busy = 0;
    begin
      int n = 0;
      while (log_q.size() < 8 && n < 200) begin
        if (a_ack) a_req = 0;
        tick(1); n++;
      end
    end
    chk("refresh_order", log_str(8), "RRRRARRR");
    chk("refresh_wdm", last_wdm, 2'b11);

    // B write with byte mask at the top address
    do_reset();
    busy_len = 3;
    b_we = 1; b_wdm = 2'b01; b_wdata = 16'h12AB; b_addr = 22'h3FFFFF; b_req = 1;
    wait_ack(1, "wr_ack");
    b_req = 0;
    tick(20);
    chk("wr_strobe_cnt", wr_n, 1);
    chk("wr_rd_cnt", rd_n, 0);
    chk("wr_din", last_din, 16'h12AB);
    chk("wr_wdm", last_wdm, 2'b01);
    chk("wr_addr", last_addr, 22'h3FFFFF);
    chk("wr_back_cnt", b_ack_n, 1);
    chk("wr_no_rvalid", b_rv_n, 0);

    // Downstream never accepts: err after 8 WAIT_ACCEPT cycles
    do_reset();
    no_resp = 1; a_addr = 22'h000200; a_req = 1;
    wait_ack(0, "to_ack");
    a_req = 0;
    tick(8);
    chk("to_err_early", err, 1'b0);
    tick(1);
    chk("to_err_set", err, 1'b1);
    tick(5);
    chk("to_no_rvalid", a_rv_n, 0);
    no_resp = 0; busy_len = 2; model_dout = 16'h5555; a_req = 1;
    wait_ack(0, "to_next_ack");
    a_req = 0;
    tick(15);
    chk("to_next_rvalid", a_rv_n, 1);
    chk("to_next_rdata", a_rdata, 16'h5555);
    chk("to_err_sticky", err, 1'b1);

    // Reset during WAIT_DONE, then mc_enabled=0 blocks everything
    busy_len = 6; model_dout = 16'hCAFE; a_req = 1;
    wait_ack(0, "abort_ack");
    a_req = 0;
    tick(4);
    resetn = 1'b0; clr = 1;
    #1;
    chk("abort_strobes", {mc_read, mc_write, mc_refresh, a_ack, b_ack, a_rvalid, b_rvalid, err}, 8'h00);
    chk("abort_rdata", a_rdata, 16'h0);
    tick(2);
    clr = 0; mc_enabled = 0; a_req = 1;
    resetn = 1'b1;
    tick(200);
    chk("dis_no_ack", a_ack_n, 0);
    chk("dis_no_refresh", ref_n, 0);
    chk("abort_no_rvalid", a_rv_n, 0);
    mc_enabled = 1;
    wait_ack(0, "en_ack");
    a_req = 0;
    tick(30);
    chk("en_ack_cnt", a_ack_n, 1);
    chk("en_no_refresh", ref_n, 0);
    chk("en_rdata", a_rdata, 16'hCAFE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
